// File: rtl/jtframe_osd_tx.sv
// Sends OSD command, info-box and buffer-write words as strobed 16-bit slots framed by io_osd.
// io_osd rises the cycle after req is accepted; done pulses GAP cycles after the last slot; req is ignored while busy.
module jtframe_osd_tx #(
    parameter int STB_LO = 2,
    parameter int STB_HI = 2,
    parameter int GAP    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [1:0]  op,
    input  logic [4:0]  page,
    input  logic [12:0] len,
    input  logic [11:0] info_x,
    input  logic [11:0] info_y,
    input  logic [5:0]  info_w,
    input  logic [5:0]  info_h,
    input  logic [1:0]  info_rot,
    output logic [12:0] mem_addr,
    input  logic [7:0]  mem_data,
    output logic        io_osd,
    output logic        io_strobe,
    output logic [15:0] io_din,
    output logic        busy,
    output logic        done
);
    localparam logic [15:0] SLOT_LAST = 16'(STB_LO + STB_HI - 1);
    localparam logic [15:0] STB_FIRST = 16'(STB_LO);
    localparam logic [15:0] GAP_LAST  = 16'(GAP - 1);

    typedef enum logic [1:0] {S_IDLE, S_SLOT, S_GAP, S_DONE} state_t;

    state_t      r_state, w_next;
    logic [15:0] r_cnt;
    logic [1:0]  r_op;
    logic [4:0]  r_page;
    logic [12:0] r_left;
    logic [2:0]  r_widx;
    logic        r_data;
    logic [11:0] r_x, r_y;
    logic [5:0]  r_w, r_h;
    logic [1:0]  r_rot;
    logic [15:0] r_din;
    logic [12:0] r_addr;
    logic        w_slot_end, w_last;
    logic [15:0] w_first, w_info;

    assign w_slot_end = (r_cnt == SLOT_LAST);
    assign w_last     = (r_left == 13'd0);
    assign io_din     = r_din;
    assign mem_addr   = r_addr;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        io_osd    = 1'b0;
        io_strobe = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            S_IDLE: if (req) w_next = S_SLOT;
            S_SLOT: begin
                io_osd    = 1'b1;
                io_strobe = (r_cnt >= STB_FIRST);
                busy      = 1'b1;
                if (w_slot_end && w_last) w_next = S_GAP;
            end
            S_GAP: begin
                busy = 1'b1;
                if (r_cnt == GAP_LAST) w_next = S_DONE;
            end
            default: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        case (op)
            2'd0:    w_first = 16'h0040;
            2'd1:    w_first = 16'h0041;
            2'd2:    w_first = 16'h0045;
            default: w_first = {8'h00, 3'b001, page};
        endcase
        case (r_widx)
            3'd1:    w_info = {4'h0, r_x};
            3'd2:    w_info = {4'h0, r_y};
            3'd3:    w_info = {10'h000, r_w};
            3'd4:    w_info = {10'h000, r_h};
            default: w_info = {14'h0000, r_rot};
        endcase
    end

    // r_left counts words still to send after the current slot
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_op   <= '0;
            r_page <= '0;
            r_left <= '0;
            r_widx <= '0;
            r_data <= 1'b0;
            r_x    <= '0;
            r_y    <= '0;
            r_w    <= '0;
            r_h    <= '0;
            r_rot  <= '0;
            r_din  <= '0;
            r_addr <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (req) begin
                    r_op   <= op;
                    r_page <= page;
                    r_x    <= info_x;
                    r_y    <= info_y;
                    r_w    <= info_w;
                    r_h    <= info_h;
                    r_rot  <= info_rot;
                    r_cnt  <= '0;
                    r_widx <= 3'd1;
                    r_data <= 1'b0;
                    r_din  <= w_first;
                    case (op)
                        2'd2:    r_left <= 13'd5;
                        2'd3:    r_left <= len;
                        default: r_left <= '0;
                    endcase
                end
                S_SLOT: begin
                    r_cnt <= w_slot_end ? 16'd0 : r_cnt + 16'd1;
                    // read data arrives the cycle after the address is presented
                    if (r_data && r_cnt == 16'd1) r_din <= {8'h00, mem_data};
                    if (w_slot_end && !w_last) begin
                        r_left <= r_left - 13'd1;
                        if (r_op == 2'd3) begin
                            r_data <= 1'b1;
                            r_addr <= r_data ? r_addr + 13'd1 : {r_page, 8'h00};
                        end else begin
                            r_din  <= w_info;
                            r_widx <= r_widx + 3'd1;
                        end
                    end
                end
                S_GAP:   r_cnt <= r_cnt + 16'd1;
                default: r_cnt <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_jtframe_osd_tx.sv
// Bench for jtframe_osd_tx: spec vector table, reset/abuse sequences and random transactions vs a word-list model.
module tb_jtframe_osd_tx;
    localparam int LO = 2, HI = 2, SN = LO + HI, GP = 4;

    logic        clk = 1'b0;
    logic        rst, req;
    logic [1:0]  op;
    logic [4:0]  page;
    logic [12:0] len;
    logic [11:0] info_x, info_y;
    logic [5:0]  info_w, info_h;
    logic [1:0]  info_rot;
    logic [12:0] mem_addr;
    logic [7:0]  mem_data;
    logic        io_osd, io_strobe, busy, done;
    logic [15:0] io_din;

    jtframe_osd_tx #(.STB_LO(LO), .STB_HI(HI), .GAP(GP)) dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .page(page), .len(len),
        .info_x(info_x), .info_y(info_y), .info_w(info_w), .info_h(info_h),
        .info_rot(info_rot), .mem_addr(mem_addr), .mem_data(mem_data),
        .io_osd(io_osd), .io_strobe(io_strobe), .io_din(io_din),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) mem_data <= mem_addr[7:0] ^ 8'hA5;

    typedef struct packed {
        logic [1:0]  op;
        logic [4:0]  page;
        logic [12:0] len;
        logic [11:0] x, y;
        logic [5:0]  w, h;
        logic [1:0]  rot;
    } txn_t;

    typedef struct packed {
        txn_t             t;
        int               nw;
        int               edone;
        logic [5:0][15:0] ew;
    } vec_t;

    int errors = 0, checks = 0;
    logic [15:0] got_w[$];
    logic [12:0] got_a[$];
    int got_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic txn_t mk(input int o, input int p, input int l, input int x, input int y,
                                input int w, input int h, input int r);
        txn_t c;
        c.op = 2'(o); c.page = 5'(p); c.len = 13'(l);
        c.x = 12'(x); c.y = 12'(y); c.w = 6'(w); c.h = 6'(h); c.rot = 2'(r);
        return c;
    endfunction

    function automatic int nwords(input txn_t c);
        if (c.op == 2'd3) return 1 + int'(c.len);
        if (c.op == 2'd2) return 6;
        return 1;
    endfunction

    function automatic logic [12:0] model_addr(input txn_t c, input int k);
        return 13'((int'(c.page) * 256 + k - 1) % 8192);
    endfunction

    // word k of the transaction: command/info from the field list, data from the byte source
    function automatic logic [15:0] model_word(input txn_t c, input int k);
        logic [12:0] a;
        logic [15:0] wd;
        wd = 16'h0000;
        if (k == 0) begin
            case (c.op)
                2'd0:    wd = 16'h0040;
                2'd1:    wd = 16'h0041;
                2'd2:    wd = 16'h0045;
                default: wd = 16'h0020 | {11'h0, c.page};
            endcase
        end else if (c.op == 2'd2) begin
            case (k)
                1:       wd = {4'h0, c.x};
                2:       wd = {4'h0, c.y};
                3:       wd = {10'h0, c.w};
                4:       wd = {10'h0, c.h};
                default: wd = {14'h0, c.rot};
            endcase
        end else begin
            a  = model_addr(c, k);
            wd = {8'h00, a[7:0] ^ 8'hA5};
        end
        return wd;
    endfunction

    task automatic apply(input txn_t c);
        op = c.op; page = c.page; len = c.len;
        info_x = c.x; info_y = c.y; info_w = c.w; info_h = c.h; info_rot = c.rot;
    endtask

    // Drives one request and samples every cycle up to one past done; returns at cycle done+2.
    task automatic run_txn(input txn_t c, input bit hold, input bit scramble, input string tag);
        int W, SNW, ED, k;
        int bad_osd, bad_stb, bad_busy, bad_c0, bad_stab, bad_w, bad_a;
        bit e_osd;
        logic prev_s;
        logic [15:0] cur;
        W = nwords(c); SNW = W * SN; ED = SNW + GP + 1;
        bad_osd = 0; bad_stb = 0; bad_busy = 0; bad_c0 = 0; bad_stab = 0; bad_w = 0; bad_a = 0;
        got_w.delete(); got_a.delete(); got_done = -1;
        apply(c);
        req = 1'b1;
        @(posedge clk); #1;
        if (!hold) req = 1'b0;
        prev_s = 1'b0; cur = 16'h0;
        for (int t = 1; t <= ED + 1; t++) begin
            e_osd = (t <= SNW);
            if (io_osd !== e_osd) bad_osd++;
            if (io_strobe !== (e_osd && ((t - 1) % SN) >= LO)) bad_stb++;
            if (busy !== (t < ED)) bad_busy++;
            if (done === 1'b1 && got_done < 0) got_done = t;
            if (io_strobe === 1'b1 && prev_s !== 1'b1) begin
                got_w.push_back(io_din);
                cur = io_din;
            end else if (io_strobe === 1'b1 && io_din !== cur) bad_stab++;
            if (e_osd && ((t - 1) % SN) == 0) begin
                k = (t - 1) / SN;
                if (c.op == 2'd3 && k > 0) got_a.push_back(mem_addr);
                else if (io_din !== model_word(c, k)) bad_c0++;
            end
            prev_s = io_strobe;
            if (scramble) apply(mk($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom));
            @(posedge clk); #1;
        end
        for (int i = 0; i < got_w.size() && i < W; i++)
            if (got_w[i] !== model_word(c, i)) bad_w++;
        for (int i = 0; i < got_a.size(); i++)
            if (got_a[i] !== model_addr(c, i + 1)) bad_a++;
        check({tag, " osd_cycles_bad"}, 32'(bad_osd), 0);
        check({tag, " strobe_cycles_bad"}, 32'(bad_stb), 0);
        check({tag, " busy_cycles_bad"}, 32'(bad_busy), 0);
        check({tag, " done_cycle"}, 32'(got_done), 32'(ED));
        check({tag, " word_count"}, 32'(got_w.size()), 32'(W));
        check({tag, " words_bad"}, 32'(bad_w), 0);
        check({tag, " slot0_din_bad"}, 32'(bad_c0), 0);
        check({tag, " din_unstable"}, 32'(bad_stab), 0);
        if (c.op == 2'd3) begin
            check({tag, " addr_count"}, 32'(got_a.size()), 32'(c.len));
            check({tag, " addrs_bad"}, 32'(bad_a), 0);
        end
    endtask

    vec_t vecs[6];
    logic [15:0] gw;
    txn_t rc;
    int   n;

    initial begin
        vecs[0].t = mk(0, 0, 0, 0, 0, 0, 0, 0);  vecs[0].nw = 1; vecs[0].edone = 9;
        vecs[0].ew = {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0040};
        vecs[1].t = mk(1, 0, 0, 0, 0, 0, 0, 0);  vecs[1].nw = 1; vecs[1].edone = 9;
        vecs[1].ew = {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0041};
        vecs[2].t = mk(2, 0, 0, 'h123, 'h045, 20, 8, 1); vecs[2].nw = 6; vecs[2].edone = 29;
        vecs[2].ew = {16'h0001, 16'h0008, 16'h0014, 16'h0045, 16'h0123, 16'h0045};
        vecs[3].t = mk(3, 3, 4, 0, 0, 0, 0, 0);  vecs[3].nw = 5; vecs[3].edone = 25;
        vecs[3].ew = {16'h0, 16'h00A6, 16'h00A7, 16'h00A4, 16'h00A5, 16'h0023};
        vecs[4].t = mk(3, 9, 0, 0, 0, 0, 0, 0);  vecs[4].nw = 1; vecs[4].edone = 9;
        vecs[4].ew = {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0029};
        vecs[5].t = mk(3, 31, 300, 0, 0, 0, 0, 0); vecs[5].nw = 301; vecs[5].edone = 1209;
        vecs[5].ew = {16'h00A1, 16'h00A6, 16'h00A7, 16'h00A4, 16'h00A5, 16'h003F};

        rst = 1'b1; req = 1'b0;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0));
        repeat (3) @(posedge clk);
        #1;
        check("rst io_osd", 32'(io_osd), 0);
        check("rst io_strobe", 32'(io_strobe), 0);
        check("rst io_din", 32'(io_din), 0);
        check("rst mem_addr", 32'(mem_addr), 0);
        check("rst busy", 32'(busy), 0);
        check("rst done", 32'(done), 0);
        req = 1'b1; op = 2'd1;
        @(posedge clk); #1;
        check("rst+req busy", 32'(busy), 0);
        check("rst+req io_osd", 32'(io_osd), 0);
        rst = 1'b0; req = 1'b0;
        @(posedge clk); #1;
        check("after rst+req io_osd", 32'(io_osd), 0);
        check("after rst+req busy", 32'(busy), 0);

        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i].t, 1'b0, 1'b0, $sformatf("vec%0d", i));
            check($sformatf("vec%0d nwords", i), 32'(got_w.size()), 32'(vecs[i].nw));
            check($sformatf("vec%0d done_at", i), 32'(got_done), 32'(vecs[i].edone));
            for (int j = 0; j < 6 && j < vecs[i].nw; j++) begin
                gw = (j < got_w.size()) ? got_w[j] : 16'hxxxx;
                check($sformatf("vec%0d word%0d", i, j), 32'(gw), 32'(vecs[i].ew[j]));
            end
            if (i == 5 && got_a.size() >= 300) begin
                check("wrap addr first", 32'(got_a[0]), 32'h1F00);
                check("wrap addr 255", 32'(got_a[255]), 32'h1FFF);
                check("wrap addr 256", 32'(got_a[256]), 32'h0000);
                check("wrap addr last", 32'(got_a[299]), 32'h002B);
            end
        end

        // req held high: one transaction, next accepted on the edge after the post-done idle cycle
        run_txn(mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0, "hold");
        check("hold restart io_osd", 32'(io_osd), 1);
        req = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("hold second done", 32'(done), 1);
        @(posedge clk); #1;

        // reset during data slot 2 of a write
        apply(mk(3, 5, 4, 0, 0, 0, 0, 0));
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (13) @(posedge clk);
        #1;
        check("midrst pre io_osd", 32'(io_osd), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst io_osd", 32'(io_osd), 0);
        check("midrst io_strobe", 32'(io_strobe), 0);
        check("midrst busy", 32'(busy), 0);
        check("midrst io_din", 32'(io_din), 0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1 || io_osd === 1'b1) n++;
            @(posedge clk); #1;
        end
        check("midrst no_done_or_osd", 32'(n), 0);
        run_txn(mk(3, 7, 3, 0, 0, 0, 0, 0), 1'b0, 1'b0, "post_rst");

        for (int i = 0; i < 25; i++) begin
            rc = mk($urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 40),
                    $urandom, $urandom, $urandom, $urandom, $urandom);
            run_txn(rc, 1'b0, 1'b1, $sformatf("rnd%0d", i));
            req = 1'b0;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/jtframe_osd_tx.md
JTFRAME_OSD_TX -- requirements
Module: jtframe_osd_tx

Interface
REQ-001 SHALL have parameter STB_LO, default 2: strobe-low cycles per word slot; legal values are 2 or more.
REQ-002 SHALL have parameter STB_HI, default 2: strobe-high cycles per word slot; legal values are 1 or more.
REQ-003 SHALL have parameter GAP, default 4: io_osd-low cycles after the last slot, before done; legal values are 1 or more.
REQ-004 clk  in  1  single clock; every register is on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req  in  1  start request; sampled only in IDLE.
REQ-007 op  in  2  transaction type: 0 disable, 1 enable menu, 2 enable info box, 3 buffer write.
REQ-008 page  in  5  start page for writes; base address = {page, 8'h00}.
REQ-009 len  in  13  number of bytes to write; 0 is legal.
REQ-010 info_x, info_y  in  12 each  info-box position.
REQ-011 info_w, info_h  in  6 each  info-box size in 8-pixel units.
REQ-012 info_rot  in  2  info-box rotation.
REQ-013 mem_addr  out  13  byte-source read address.
REQ-014 mem_data  in  8  byte-source read data, valid 1 cycle after mem_addr.
REQ-015 io_osd  out  1  transaction frame.
REQ-016 io_strobe  out  1  word strobe; the receiver latches on the rising edge.
REQ-017 io_din  out  16  word bus.
REQ-018 busy  out  1  transaction in progress.
REQ-019 done  out  1  one-cycle completion pulse.

Function
REQ-020 SHALL implement states IDLE, SLOT, GAP, DONE; req=1 in IDLE latches op, page, len and all info fields and moves to SLOT.
REQ-021 SHALL ignore req while busy=1; latched parameters SHALL NOT change mid-transaction.
REQ-022 SHALL send the word sequence for each op as follows:
- op 0: 0x0040.
- op 1: 0x0041.
- op 2: 0x0045, then {4'h0,info_x}, {4'h0,info_y}, {10'h0,info_w}, {10'h0,info_h}, {14'h0,info_rot}.
- op 3: {8'h00,3'b001,page}, then len data words {8'h00,byte}.
REQ-023 Each word SHALL occupy one slot of STB_LO+STB_HI cycles: io_strobe=0 for the first STB_LO cycles and 1 for the last STB_HI cycles.
REQ-024 Slots SHALL be back-to-back; io_osd SHALL be 1 for exactly W*(STB_LO+STB_HI) contiguous cycles, where W is the word count.
REQ-025 Taking the acceptance edge as cycle 0, io_osd SHALL rise in cycle 1.
REQ-026 Command and info words SHALL appear on io_din in slot cycle 0 and stay stable to the end of the slot.
REQ-027 Data slot i SHALL:
- drive mem_addr = ({page,8'h00}+i) mod 8192 in slot cycle 0;
- load io_din[7:0] from mem_data in slot cycle 1;
- keep io_din stable from there to the end of the slot.
REQ-028 The address SHALL wrap from 0x1FFF to 0x0000; the byte counter SHALL be 13 bits.
REQ-029 An op 3 with len=0 SHALL send only the command word.
REQ-030 After the last slot, io_osd and io_strobe SHALL be 0 for GAP cycles.
REQ-031 In the following cycle (state DONE), done SHALL be 1 and busy SHALL be 0; the block then returns to IDLE.
REQ-032 req=1 in the DONE cycle SHALL be ignored; req is accepted from the next cycle on.
REQ-033 busy SHALL be 1 from cycle 1 through the last GAP cycle, so done occurs at cycle W*(STB_LO+STB_HI)+GAP+1.
REQ-034 Outside SLOT, io_strobe SHALL be 0; io_din SHALL hold its last value.

Reset
REQ-035 rst=1 SHALL force, on the next edge, state=IDLE and io_osd=0, io_strobe=0, io_din=0, mem_addr=0, busy=0, done=0.
REQ-036 rst SHALL take priority over req and over any in-flight slot; no done pulse SHALL follow a reset.

Verification
REQ-037 Reset check: hold rst 3 cycles -> all outputs 0; with rst=1 and req=1 together -> nothing starts.
REQ-038 Disable, defaults: op=0, req pulse at cycle 0 ->
- io_osd=1 in cycles 1-4;
- io_strobe=1 in cycles 3-4;
- io_din=0x0040;
- done in cycle 9, busy 1 in cycles 1-8.
REQ-039 Info enable: op=2, x=0x123, y=0x045, w=20, h=8, rot=1 ->
- words 0x0045, 0x0123, 0x0045, 0x0014, 0x0008, 0x0001;
- six strobe rising edges, at cycles 3, 7, 11, 15, 19, 23;
- done in cycle 29.
REQ-040 Write: op=3, page=3, len=4, memory byte = addr[7:0]^0xA5 ->
- words 0x0023, 0x00A5, 0x00A4, 0x00A7, 0x00A6;
- mem_addr sequence 0x300-0x303;
- done in cycle 25.
REQ-041 Wrap and len=0:
- op=3, page=31, len=300 -> mem_addr runs 0x1F00-0x1FFF then 0x0000-0x002B, giving 301 strobes;
- op=3, len=0 -> a single 0x0020|page word.
REQ-042 Abuse:
- req held high through a whole transaction -> exactly one transaction, then a new one starts only from the cycle after done;
- rst during data slot 2 -> io_osd=0 and io_strobe=0 the next cycle, no done, and a fresh req completes normally.
